// File: rtl/ram_lsu_pkg.sv
// ============================================================================
// ram_lsu_pkg : shared funct3 codes, FSM states and response record (rev 1.0)
// ============================================================================
`default_nettype none

package ram_lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  typedef struct packed {
    logic        valid;
    logic        err;
    logic [31:0] rdata;
  } rsp_t;

  localparam rsp_t RSP_IDLE = '{valid: 1'b0, err: 1'b0, rdata: 32'h0};

endpackage

`default_nettype wire

// File: rtl/ram_lsu_if.sv
// ============================================================================
// ram_lsu_if : request/response bus between core memory stage and ram_lsu (rev 1.0)
// ============================================================================
`default_nettype none

interface ram_lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

`default_nettype wire

// File: rtl/ram_lsu_lane.sv
// ============================================================================
// ram_lsu_lane : byte-lane steering, load extension and access checking (rev 1.0)
// ============================================================================
`default_nettype none

module ram_lsu_lane
  import ram_lsu_pkg::*;
(
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata,
  output logic        access_err
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    be         = 4'b0000;
    wdata_rep  = 32'h0;
    rdata      = 32'h0;
    access_err = 1'b0;
    half_sel   = addr_lo[1] ? rword[31:16] : rword[15:0];
    case (addr_lo)
      2'd0:    byte_sel = rword[7:0];
      2'd1:    byte_sel = rword[15:8];
      2'd2:    byte_sel = rword[23:16];
      default: byte_sel = rword[31:24];
    endcase

    // access_err covers misalignment and funct3 codes illegal for the direction
    case (funct3)
      F3_B: begin
        be        = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
        rdata     = {{24{byte_sel[7]}}, byte_sel};
      end
      F3_BU: begin
        access_err = we;
        rdata      = {24'h0, byte_sel};
      end
      F3_H: begin
        access_err = addr_lo[0];
        be         = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_rep  = {2{wdata[15:0]}};
        rdata      = {{16{half_sel[15]}}, half_sel};
      end
      F3_HU: begin
        access_err = addr_lo[0] | we;
        rdata      = {16'h0, half_sel};
      end
      F3_W: begin
        access_err = (addr_lo != 2'b00);
        be         = 4'b1111;
        wdata_rep  = wdata;
        rdata      = rword;
      end
      default: access_err = 1'b1;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/ram_lsu.sv
// ============================================================================
// ram_lsu : word RAM with RISC-V load/store front end and fixed-latency response (rev 1.0)
// ============================================================================
`default_nettype none

module ram_lsu
  import ram_lsu_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 1
) (
  input  logic       clk,
  input  logic       rst,
  ram_lsu_if.slave   bus
);

  localparam int AW = $clog2(DEPTH);

  state_e         state_q, state_d;
  logic [AW-1:0]  cnt_q, cnt_d;
  rsp_t           s1_q, s1_d;
  rsp_t           rsp_out;

  logic [31:0]    mem [DEPTH];

  logic [AW-1:0]  widx;
  logic           oor;
  logic           accept;
  logic           lane_err;
  logic           req_err;
  logic           mem_we;
  logic [3:0]     be;
  logic [31:0]    rword;
  logic [31:0]    wdata_rep;
  logic [31:0]    ld_data;

  assign widx          = bus.req_addr[AW+1:2];
  assign oor           = |bus.req_addr[31:AW+2];
  assign rword         = mem[widx];
  assign bus.req_ready = (state_q == RUN);
  assign accept        = bus.req_valid && bus.req_ready;
  assign req_err       = lane_err | oor;
  assign mem_we        = accept && bus.req_we && !req_err;

  ram_lsu_lane u_lane (
    .we         (bus.req_we),
    .funct3     (bus.req_funct3),
    .addr_lo    (bus.req_addr[1:0]),
    .wdata      (bus.req_wdata),
    .rword      (rword),
    .be         (be),
    .wdata_rep  (wdata_rep),
    .rdata      (ld_data),
    .access_err (lane_err)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == INIT) begin
      cnt_d = cnt_q + AW'(1);
      if (cnt_q == AW'(DEPTH - 1)) begin
        state_d = RUN;
      end
    end
  end

  always_comb begin
    s1_d       = RSP_IDLE;
    s1_d.valid = accept;
    s1_d.err   = accept && req_err;
    s1_d.rdata = (accept && !bus.req_we && !req_err) ? ld_data : 32'h0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= INIT;
      cnt_q   <= '0;
      s1_q    <= RSP_IDLE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      s1_q    <= s1_d;
    end
  end

  // Array has no reset; the INIT sweep is the only way it gets cleared
  always_ff @(posedge clk) begin
    if (state_q == INIT) begin
      mem[cnt_q] <= 32'h0;
    end else if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) begin
          mem[widx][b*8 +: 8] <= wdata_rep[b*8 +: 8];
        end
      end
    end
  end

  generate
    if (LATENCY == 2) begin : g_lat2
      rsp_t s2_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          s2_q <= RSP_IDLE;
        end else begin
          s2_q <= s1_q;
        end
      end
      assign rsp_out = s2_q;
    end else begin : g_lat1
      assign rsp_out = s1_q;
    end
  endgenerate

  assign bus.rsp_valid = rsp_out.valid;
  assign bus.rsp_err   = rsp_out.err;
  assign bus.rsp_rdata = rsp_out.rdata;

endmodule

`default_nettype wire

// File: tb/tb_ram_lsu.sv
// ============================================================================
// tb_ram_lsu : directed bench driving LATENCY=1 and LATENCY=2 instances in lockstep (rev 1.0)
// ============================================================================
`default_nettype none

module tb_ram_lsu;
  import ram_lsu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  ram_lsu_if bus1 ();
  ram_lsu_if bus2 ();

  ram_lsu #(.DEPTH(16), .LATENCY(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
  ram_lsu #(.DEPTH(16), .LATENCY(2)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_rsp(input string tag, input int dut, input logic v, input logic e,
                         input logic [31:0] d);
    logic        ov, oe;
    logic [31:0] od;
    if (dut == 1) begin
      ov = bus1.rsp_valid; oe = bus1.rsp_err; od = bus1.rsp_rdata;
    end else begin
      ov = bus2.rsp_valid; oe = bus2.rsp_err; od = bus2.rsp_rdata;
    end
    chk($sformatf("%s/L%0d/valid", tag, dut), 32'(ov), 32'(v));
    chk($sformatf("%s/L%0d/err", tag, dut), 32'(oe), 32'(e));
    chk($sformatf("%s/L%0d/rdata", tag, dut), od, d);
  endtask

  task automatic drive(input logic v, input logic we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
    bus1.req_valid = v; bus1.req_we = we; bus1.req_funct3 = f3;
    bus1.req_addr  = a; bus1.req_wdata = wd;
    bus2.req_valid = v; bus2.req_we = we; bus2.req_funct3 = f3;
    bus2.req_addr  = a; bus2.req_wdata = wd;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
  endtask

  // Single isolated request; entered and left one time unit after a rising edge
  task automatic req(input string tag, input logic we, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] wd,
                     input logic e, input logic [31:0] d);
    drive(1'b1, we, f3, a, wd);
    @(posedge clk); #1;
    idle();
    chk_rsp({tag, "@1"}, 1, 1'b1, e, d);
    chk_rsp({tag, "@1"}, 2, 1'b0, 1'b0, 32'h0);
    @(posedge clk); #1;
    chk_rsp({tag, "@2"}, 1, 1'b0, 1'b0, 32'h0);
    chk_rsp({tag, "@2"}, 2, 1'b1, e, d);
  endtask

  // Counts the 16 init edges; a store is held on the bus for the first 8 to show it is ignored
  task automatic wait_init(input string tag, input logic poke);
    if (poke) drive(1'b1, 1'b1, F3_W, 32'h0, 32'hFFFF_FFFF);
    for (int i = 1; i <= 16; i++) begin
      @(posedge clk); #1;
      if (i == 8) idle();
      if (i < 16) begin
        chk($sformatf("%s/rdy1_e%0d", tag, i), 32'(bus1.req_ready), 32'd0);
        chk($sformatf("%s/rdy2_e%0d", tag, i), 32'(bus2.req_ready), 32'd0);
      end else begin
        chk($sformatf("%s/rdy1_e%0d", tag, i), 32'(bus1.req_ready), 32'd1);
        chk($sformatf("%s/rdy2_e%0d", tag, i), 32'(bus2.req_ready), 32'd1);
      end
      chk($sformatf("%s/rv1_e%0d", tag, i), 32'(bus1.rsp_valid), 32'd0);
      chk($sformatf("%s/rv2_e%0d", tag, i), 32'(bus2.rsp_valid), 32'd0);
    end
  endtask

  initial begin
    idle();
    #2 rst = 1'b1;
    #1;
    chk("rst/rdy1", 32'(bus1.req_ready), 32'd0);
    chk("rst/rdy2", 32'(bus2.req_ready), 32'd0);
    chk_rsp("rst", 1, 1'b0, 1'b0, 32'h0);
    chk_rsp("rst", 2, 1'b0, 1'b0, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    wait_init("init", 1'b0);

    req("lw3c",  1'b0, F3_W,  32'h3C, 32'h0,         1'b0, 32'h0000_0000);
    req("sw0",   1'b1, F3_W,  32'h00, 32'h1122_3344, 1'b0, 32'h0);
    req("sb2",   1'b1, F3_B,  32'h02, 32'h0000_00AA, 1'b0, 32'h0);
    req("lw0",   1'b0, F3_W,  32'h00, 32'h0,         1'b0, 32'h11AA_3344);
    req("lb2",   1'b0, F3_B,  32'h02, 32'h0,         1'b0, 32'hFFFF_FFAA);
    req("lbu2",  1'b0, F3_BU, 32'h02, 32'h0,         1'b0, 32'h0000_00AA);
    req("sb3",   1'b1, F3_B,  32'h03, 32'h0000_005A, 1'b0, 32'h0);
    req("lb3",   1'b0, F3_B,  32'h03, 32'h0,         1'b0, 32'h0000_005A);
    req("lw0b",  1'b0, F3_W,  32'h00, 32'h0,         1'b0, 32'h5AAA_3344);
    req("sh6",   1'b1, F3_H,  32'h06, 32'h0000_8001, 1'b0, 32'h0);
    req("lh6",   1'b0, F3_H,  32'h06, 32'h0,         1'b0, 32'hFFFF_8001);
    req("lhu6",  1'b0, F3_HU, 32'h06, 32'h0,         1'b0, 32'h0000_8001);
    req("lw4",   1'b0, F3_W,  32'h04, 32'h0,         1'b0, 32'h8001_0000);

    req("lw2e",  1'b0, F3_W,  32'h02, 32'h0,         1'b1, 32'h0);
    req("sh1e",  1'b1, F3_H,  32'h01, 32'h0000_BEEF, 1'b1, 32'h0);
    req("lw0c",  1'b0, F3_W,  32'h00, 32'h0,         1'b0, 32'h5AAA_3344);
    req("oor1k", 1'b0, F3_W,  32'h1000, 32'h0,       1'b1, 32'h0);
    req("oor40", 1'b0, F3_W,  32'h40, 32'h0,         1'b1, 32'h0);
    req("f3_3",  1'b0, 3'b011, 32'h00, 32'h0,        1'b1, 32'h0);
    req("sbu_e", 1'b1, F3_BU, 32'h00, 32'h0000_00FF, 1'b1, 32'h0);
    req("lw0d",  1'b0, F3_W,  32'h00, 32'h0,         1'b0, 32'h5AAA_3344);

    // Back-to-back store then load to the same word
    drive(1'b1, 1'b1, F3_W, 32'h08, 32'hCAFE_BABE);
    @(posedge clk); #1;
    drive(1'b1, 1'b0, F3_W, 32'h08, 32'h0);
    chk_rsp("b2b@A", 1, 1'b1, 1'b0, 32'h0);
    chk_rsp("b2b@A", 2, 1'b0, 1'b0, 32'h0);
    @(posedge clk); #1;
    idle();
    chk_rsp("b2b@B", 1, 1'b1, 1'b0, 32'hCAFE_BABE);
    chk_rsp("b2b@B", 2, 1'b1, 1'b0, 32'h0);
    @(posedge clk); #1;
    chk_rsp("b2b@C", 1, 1'b0, 1'b0, 32'h0);
    chk_rsp("b2b@C", 2, 1'b1, 1'b0, 32'hCAFE_BABE);
    @(posedge clk); #1;
    chk_rsp("b2b@D", 2, 1'b0, 1'b0, 32'h0);

    // Reset with two loads in flight
    drive(1'b1, 1'b0, F3_W, 32'h00, 32'h0);
    @(posedge clk); #1;
    drive(1'b1, 1'b0, F3_W, 32'h08, 32'h0);
    @(posedge clk); #1;
    idle();
    rst = 1'b1;
    #1;
    chk_rsp("mrst", 1, 1'b0, 1'b0, 32'h0);
    chk_rsp("mrst", 2, 1'b0, 1'b0, 32'h0);
    repeat (2) begin
      @(posedge clk); #1;
      chk("mrst/rv1", 32'(bus1.rsp_valid), 32'd0);
      chk("mrst/rv2", 32'(bus2.rsp_valid), 32'd0);
    end
    rst = 1'b0;
    wait_init("reinit", 1'b1);
    req("post0", 1'b0, F3_W, 32'h00, 32'h0, 1'b0, 32'h0);
    req("post4", 1'b0, F3_W, 32'h04, 32'h0, 1'b0, 32'h0);
    req("post8", 1'b0, F3_W, 32'h08, 32'h0, 1'b0, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
